// File: rtl/axi_s_pkg.sv
// Shared AXI-Stream definitions for the axi_s_m master and axi_s_s slave stages.
package axi_s_pkg;

  localparam int AXIS_DATA_W = 8;

  typedef logic [AXIS_DATA_W-1:0] axis_data_t;

  // Counter width that stays legal (>= 1 bit) when the count range is a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_s_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
// Occupancy is tracked explicitly so pointers can wrap naturally.
module axi_s_fifo
  import axi_s_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AXIS_DATA_W-1:0]   wdata,
  output logic [AXIS_DATA_W-1:0]   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  axis_data_t      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            push_s;
  logic            pop_s;

  // Writes into a full FIFO or reads from an empty one are ignored.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign full  = (level_r == LVL_FULL);
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;
  assign rdata = mem_r[rd_ptr_r];

endmodule

// File: rtl/axi_s_m.sv
// AXI-Stream master: buffers producer bytes and emits fixed-length packets with generated tlast.
// Optional stall counter output is enabled by defining AXIS_M_STALL_CNT_EN.
module axi_s_m
  import axi_s_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                     m_aclk,
  input  logic                     m_resetn,
  input  logic [AXIS_DATA_W-1:0]   din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [AXIS_DATA_W-1:0]   m_tdata,
  output logic                     m_tlast,
  output logic                     pkt_done,
  output logic [$clog2(DEPTH):0]   level
`ifdef AXIS_M_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int BW = cnt_w(PKT_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  axis_data_t      head_s;
  logic            last_beat_s;
  logic [BW-1:0]   beat_cnt_r;
  logic [BW-1:0]   beat_cnt_nxt_s;
  logic            pkt_done_r;

  assign push_s = din_valid && din_ready;
  assign pop_s  = m_tvalid && m_tready;

  axi_s_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (m_aclk),
    .rst_n (m_resetn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (din),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // No same-cycle bypass: a slot freed by a pop is offered only on the next cycle.
  assign din_ready   = !full_s;
  assign m_tvalid    = !empty_s;
  assign m_tdata     = head_s;
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  assign m_tlast     = m_tvalid && last_beat_s;

  // Beat position within the packet advances only on accepted beats.
  always_comb begin
    beat_cnt_nxt_s = beat_cnt_r;
    if (pop_s) begin
      if (last_beat_s) begin
        beat_cnt_nxt_s = {BW{1'b0}};
      end else begin
        beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
      end
    end else begin
      beat_cnt_nxt_s = beat_cnt_r;
    end
  end

  // Framing counter and end-of-packet pulse.
  always_ff @(posedge m_aclk or negedge m_resetn) begin
    if (!m_resetn) begin
      beat_cnt_r <= {BW{1'b0}};
      pkt_done_r <= 1'b0;
    end else begin
      beat_cnt_r <= beat_cnt_nxt_s;
      pkt_done_r <= pop_s && last_beat_s;
    end
  end

  assign pkt_done = pkt_done_r;

`ifdef AXIS_M_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where a valid beat is held off by the slave.
  always_ff @(posedge m_aclk or negedge m_resetn) begin
    if (!m_resetn) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (m_tvalid && !m_tready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_axi_s_m.sv
// Directed self-checking bench for axi_s_m (DEPTH=8, PKT_LEN=4).
module tb_axi_s_m;

  logic       m_aclk = 1'b0;
  logic       m_resetn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic       pkt_done;
  logic [3:0] level;
`ifdef AXIS_M_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 m_aclk = ~m_aclk;

  axi_s_m #(.DEPTH(8), .PKT_LEN(4)) dut (
`ifdef AXIS_M_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .m_aclk    (m_aclk),
    .m_resetn  (m_resetn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .pkt_done  (pkt_done),
    .level     (level)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge m_aclk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    repeat (5) begin
      tick();
      settle();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    end
    tick();
    din_valid = 1'b0;
    m_resetn  = 1'b1;
  endtask

  task automatic test_framing();
    int pushed = 0;
    int beats  = 0;
    int dones  = 0;
    logic [7:0] exp_d;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      din_valid = (pushed < 8);
      din       = 8'h10 + 8'(pushed);
      settle();
      if (pkt_done === 1'b1) dones++;
      if (m_tvalid && m_tready) begin
        exp_d = 8'h10 + 8'(beats);
        checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL frame_data: beat %0d got %h want %h", beats, m_tdata, exp_d); end
        checks++; if (m_tlast !== (beats % 4 == 3)) begin errors++; $display("FAIL frame_tlast: beat %0d got %b want %b", beats, m_tlast, (beats % 4 == 3)); end
        beats++;
      end
      if (din_valid && din_ready) pushed++;
      tick();
    end
    din_valid = 1'b0;
    m_tready  = 1'b0;
    settle();
    checks++; if (beats != 8) begin errors++; $display("FAIL frame_beats: got %0d want 8", beats); end
    checks++; if (dones != 2) begin errors++; $display("FAIL frame_pkt_done: got %0d pulses want 2", dones); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL frame_level: got %0d want 0", level); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pushed = 0;
    int beats  = 0;
    int dones  = 0;
    logic [7:0] exp_d;
    m_tready  = 1'b1;
    din_valid = 1'b1;
    din       = 8'h40;
    tick();
    din = 8'h41;
    settle();
    checks++; if (m_tdata !== 8'h40 || m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_beat0: got v=%b d=%h want v=1 d=40", m_tvalid, m_tdata); end
    tick();
    din = 8'h42;
    settle();
    checks++; if (m_tdata !== 8'h41 || m_tlast !== 1'b0) begin errors++; $display("FAIL mid_beat1: got d=%h l=%b want d=41 l=0", m_tdata, m_tlast); end
    tick();
    din_valid = 1'b0;
    m_tready  = 1'b0;
    settle();
    checks++; if (level !== 4'd1 || m_tdata !== 8'h42) begin errors++; $display("FAIL mid_hold: got lvl=%0d d=%h want lvl=1 d=42", level, m_tdata); end
    #1 m_resetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_tvalid: got %b want 0", m_tvalid); end
    checks++; if (level !== 4'd0 || din_ready !== 1'b1) begin errors++; $display("FAIL mid_async_level: got lvl=%0d rdy=%b want lvl=0 rdy=1", level, din_ready); end
    tick();
    m_resetn = 1'b1;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      din_valid = (pushed < 4);
      din       = 8'h50 + 8'(pushed);
      settle();
      if (pkt_done === 1'b1) dones++;
      if (m_tvalid && m_tready) begin
        exp_d = 8'h50 + 8'(beats);
        checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL mid_data: beat %0d got %h want %h", beats, m_tdata, exp_d); end
        checks++; if (m_tlast !== (beats == 3)) begin errors++; $display("FAIL mid_tlast: beat %0d got %b want %b", beats, m_tlast, (beats == 3)); end
        beats++;
      end
      if (din_valid && din_ready) pushed++;
      tick();
    end
    din_valid = 1'b0;
    m_tready  = 1'b0;
    settle();
    checks++; if (beats != 4 || dones != 1) begin errors++; $display("FAIL mid_count: got beats=%0d dones=%0d want 4 and 1", beats, dones); end
    tick();
  endtask

  task automatic test_backpressure();
    m_tready  = 1'b0;
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (6) begin
      settle();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a5", m_tvalid, m_tdata); end
      checks++; if (m_tlast !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL bp_state: got l=%b lvl=%0d want l=0 lvl=1", m_tlast, level); end
      tick();
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    settle();
    checks++; if (level !== 4'd0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: got lvl=%0d v=%b want lvl=0 v=0", level, m_tvalid); end
    tick();
  endtask

  task automatic test_full();
    m_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din       = 8'h20 + 8'(i);
      din_valid = 1'b1;
      settle();
      checks++; if (din_ready !== (i < 8)) begin errors++; $display("FAIL full_ready: push %0d got %b want %b", i, din_ready, (i < 8)); end
      tick();
    end
    din_valid = 1'b0;
    settle();
    checks++; if (level !== 4'd8 || din_ready !== 1'b0) begin errors++; $display("FAIL full_level: got lvl=%0d rdy=%b want lvl=8 rdy=0", level, din_ready); end
    checks++; if (m_tdata !== 8'h20 || m_tvalid !== 1'b1) begin errors++; $display("FAIL full_head: got v=%b d=%h want v=1 d=20", m_tvalid, m_tdata); end
    tick();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_d [8];
    logic       exp_l [8];
    exp_d = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h30};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    m_tready  = 1'b1;
    din_valid = 1'b1;
    din       = 8'h30;
    settle();
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL fp_no_bypass: got rdy=%b want 0", din_ready); end
    checks++; if (m_tlast !== 1'b0 || m_tdata !== 8'h20) begin errors++; $display("FAIL fp_head: got l=%b d=%h want l=0 d=20", m_tlast, m_tdata); end
    tick();
    m_tready = 1'b0;
    settle();
    checks++; if (level !== 4'd7 || din_ready !== 1'b1) begin errors++; $display("FAIL fp_after_pop: got lvl=%0d rdy=%b want lvl=7 rdy=1", level, din_ready); end
    tick();
    din_valid = 1'b0;
    settle();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fp_refill: got lvl=%0d want 8", level); end
    tick();
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== exp_d[k]) begin errors++; $display("FAIL fp_drain_data: beat %0d got v=%b d=%h want v=1 d=%h", k, m_tvalid, m_tdata, exp_d[k]); end
      checks++; if (m_tlast !== exp_l[k]) begin errors++; $display("FAIL fp_drain_tlast: beat %0d got %b want %b", k, m_tlast, exp_l[k]); end
      tick();
    end
    m_tready = 1'b0;
    settle();
    checks++; if (level !== 4'd0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL fp_empty: got lvl=%0d v=%b want lvl=0 v=0", level, m_tvalid); end
    tick();
  endtask

`ifdef AXIS_M_STALL_CNT_EN
  task automatic test_stall();
    m_resetn  = 1'b0;
    din_valid = 1'b0;
    m_tready  = 1'b0;
    settle();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_reset: got %0d want 0", stall_cnt); end
    tick();
    m_resetn = 1'b1;
    repeat (3) tick();
    settle();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_empty: got %0d want 0", stall_cnt); end
    tick();
    din       = 8'h77;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();
    settle();
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_count: got %0d want 5", stall_cnt); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    settle();
    checks++; if (stall_cnt !== 32'd5 || level !== 4'd0) begin errors++; $display("FAIL stall_after_pop: got cnt=%0d lvl=%0d want 5 and 0", stall_cnt, level); end
    tick();
  endtask
`endif

  initial begin
    m_resetn  = 1'b0;
    din       = 8'h55;
    din_valid = 1'b1;
    m_tready  = 1'b0;
    test_reset();
    test_framing();
    test_reset_mid();
    test_backpressure();
    test_full();
    test_full_pop();
`ifdef AXIS_M_STALL_CNT_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
